// File: rtl/fir_pkg.sv
// fir_pkg: shared types and helpers for fir_filter_mc.
//   state_t      - controller state encoding (IDLE, MAC, OUT)
//   sat_res_t    - result of saturate(): clip flag plus 64-bit clamped value
//   calc_ch_w    - channel tag width, at least one bit
//   calc_acc_w   - accumulator width that cannot overflow over TAPS products
//   saturate     - arithmetic shift (floor) followed by clamp to a signed width
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] val;
    } sat_res_t;

    function automatic int calc_ch_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int calc_acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // The accumulator is sign-extended to 64 bits by the caller, so one
    // function serves every parameterisation (ACC_W and OUT_W up to 63).
    function automatic sat_res_t saturate(input logic signed [63:0] acc,
                                          input int shift,
                                          input int out_w);
        sat_res_t           res;
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = acc >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (r > hi) begin
            res.sat = 1'b1;
            res.val = hi;
        end else if (r < lo) begin
            res.sat = 1'b1;
            res.val = lo;
        end else begin
            res.sat = 1'b0;
            res.val = r;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_mac.sv
// fir_mac: registered signed multiply-accumulate.
//   clk, rst_n  - clock, synchronous active-low reset
//   clr_i       - zero the accumulator (wins over en_i)
//   en_i        - add a_i * b_i into the accumulator
//   a_i, b_i    - signed operands
//   acc_o       - accumulator register
module fir_mac #(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int ACC_W = 19
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [A_W-1:0]   a_i,
    input  logic signed [B_W-1:0]   b_i,
    output logic signed [ACC_W-1:0] acc_o
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] acc_q, acc_d;

    // Operands widened before the multiply so the product is full precision.
    assign prod = P_W'(a_i) * P_W'(b_i);

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fir_filter_mc.sv
// fir_filter_mc: multi-channel FIR with one time-shared MAC.
//   clk, rst_n            - clock, synchronous active-low reset
//   input_data/_channel   - signed sample and its channel tag
//   input_data_flag       - sample valid; consumed when input_ready is high
//   input_ready           - high in IDLE: sample or coefficient write accepted
//   coef_wr/_addr/_data   - coefficient write port (shared by all channels)
//   output_data/_channel  - last result and its channel (held between results)
//   output_data_flag      - one-cycle pulse per result
//   output_sat            - result was clipped, valid with output_data_flag
//
// state | meaning
// IDLE  | waiting for a sample; coefficient writes honoured
// MAC   | one product per cycle, k = 0 .. TAPS-1
// OUT   | shift, saturate and register the result; advance channel pointer
module fir_filter_mc
    import fir_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int TAPS      = 8,
    parameter int CHANNELS  = 2,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 0,
    localparam int CH_W  = calc_ch_w(CHANNELS),
    localparam int AW    = $clog2(TAPS),
    localparam int ACC_W = calc_acc_w(DATA_W, COEF_W, TAPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] input_data,
    input  logic        [CH_W-1:0]   input_data_channel,
    input  logic                     input_data_flag,
    output logic                     input_ready,
    input  logic                     coef_wr,
    input  logic        [AW-1:0]     coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic signed [OUT_W-1:0]  output_data,
    output logic        [CH_W-1:0]   output_data_channel,
    output logic                     output_data_flag,
    output logic                     output_sat
);

    state_t                   state_q, state_d;
    logic        [AW-1:0]     k_q, k_d;
    logic        [CH_W-1:0]   ch_q, ch_d;
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic signed [DATA_W-1:0] hist_q [CHANNELS][TAPS];
    logic        [AW-1:0]     ptr_q  [CHANNELS];

    logic                     ch_valid;
    logic                     addr_valid;
    logic                     accept;
    logic                     coef_we;
    logic        [AW-1:0]     tap_idx;
    logic signed [ACC_W-1:0]  acc;
    sat_res_t                 sat_res;
    logic                     unused_sat_bits;

    assign input_ready = (state_q == IDLE);

    // Range checks are only needed when the tag/address width can encode
    // values beyond the channel count or filter length.
    if ((2 ** CH_W) == CHANNELS) begin : g_ch_full
        assign ch_valid = 1'b1;
    end else begin : g_ch_chk
        assign ch_valid = (int'(input_data_channel) < CHANNELS);
    end

    if ((2 ** AW) == TAPS) begin : g_addr_full
        assign addr_valid = 1'b1;
    end else begin : g_addr_chk
        assign addr_valid = (int'(coef_addr) < TAPS);
    end

    // Out-of-range channel tags are consumed (handshake completes) but dropped.
    assign accept  = input_data_flag && input_ready && ch_valid;
    assign coef_we = coef_wr && input_ready && addr_valid;

    // Delay-line tap for product k: (ptr - k) mod TAPS, valid for any TAPS.
    always_comb begin
        if (ptr_q[ch_q] >= k_q) begin
            tap_idx = ptr_q[ch_q] - k_q;
        end else begin
            tap_idx = AW'(int'(ptr_q[ch_q]) + TAPS - int'(k_q));
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        ch_d    = ch_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = MAC;
                    k_d     = '0;
                    ch_d    = input_data_channel;
                end
            end
            MAC: begin
                if (k_q == AW'(TAPS - 1)) begin
                    state_d = OUT;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    fir_mac #(
        .A_W   (DATA_W),
        .B_W   (COEF_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (accept),
        .en_i  (state_q == MAC),
        .a_i   (hist_q[ch_q][tap_idx]),
        .b_i   (coef_q[k_q]),
        .acc_o (acc)
    );

    assign sat_res         = saturate(64'(acc), OUT_SHIFT, OUT_W);
    assign unused_sat_bits = ^sat_res.val;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q             <= IDLE;
            k_q                 <= '0;
            ch_q                <= '0;
            output_data         <= '0;
            output_data_channel <= '0;
            output_data_flag    <= 1'b0;
            output_sat          <= 1'b0;
            for (int t = 0; t < TAPS; t++) begin
                coef_q[t] <= '0;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                ptr_q[c] <= '0;
                for (int t = 0; t < TAPS; t++) begin
                    hist_q[c][t] <= '0;
                end
            end
        end else begin
            state_q          <= state_d;
            k_q              <= k_d;
            ch_q             <= ch_d;
            output_data_flag <= 1'b0;

            if (coef_we) begin
                coef_q[coef_addr] <= coef_data;
            end

            if (accept) begin
                hist_q[input_data_channel][ptr_q[input_data_channel]] <= input_data;
            end

            if (state_q == OUT) begin
                output_data         <= OUT_W'(sat_res.val);
                output_sat          <= sat_res.sat;
                output_data_channel <= ch_q;
                output_data_flag    <= 1'b1;
                ptr_q[ch_q]         <= (ptr_q[ch_q] == AW'(TAPS - 1)) ? '0
                                                                      : ptr_q[ch_q] + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fir_filter_mc.sv
module tb_fir_filter_mc;

    logic clk;
    logic rst_n;

    // DUT A: defaults (2 channels, 16-bit output, no shift)
    logic signed [7:0]  a_data;
    logic        [0:0]  a_ch;
    logic               a_flag;
    logic               a_ready;
    logic               a_cwr;
    logic        [2:0]  a_caddr;
    logic signed [7:0]  a_cdata;
    logic signed [15:0] a_out;
    logic        [0:0]  a_och;
    logic               a_oflag;
    logic               a_osat;

    // DUT B: 3 channels, 8-bit output, shift 2
    logic signed [7:0]  b_data;
    logic        [1:0]  b_ch;
    logic               b_flag;
    logic               b_ready;
    logic               b_cwr;
    logic        [2:0]  b_caddr;
    logic signed [7:0]  b_cdata;
    logic signed [7:0]  b_out;
    logic        [1:0]  b_och;
    logic               b_oflag;
    logic               b_osat;

    fir_filter_mc dut_a (
        .clk                 (clk),
        .rst_n               (rst_n),
        .input_data          (a_data),
        .input_data_channel  (a_ch),
        .input_data_flag     (a_flag),
        .input_ready         (a_ready),
        .coef_wr             (a_cwr),
        .coef_addr           (a_caddr),
        .coef_data           (a_cdata),
        .output_data         (a_out),
        .output_data_channel (a_och),
        .output_data_flag    (a_oflag),
        .output_sat          (a_osat)
    );

    fir_filter_mc #(
        .CHANNELS  (3),
        .OUT_W     (8),
        .OUT_SHIFT (2)
    ) dut_b (
        .clk                 (clk),
        .rst_n               (rst_n),
        .input_data          (b_data),
        .input_data_channel  (b_ch),
        .input_data_flag     (b_flag),
        .input_ready         (b_ready),
        .coef_wr             (b_cwr),
        .coef_addr           (b_caddr),
        .coef_data           (b_cdata),
        .output_data         (b_out),
        .output_data_channel (b_och),
        .output_data_flag    (b_oflag),
        .output_sat          (b_osat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Selected DUT (0 = A, 1 = B) and its outputs widened for comparison.
    int     sel = 0;
    logic   obs_flag;
    logic   obs_ready;
    logic   obs_sat;
    longint obs_out;
    int     obs_ch;

    always_comb begin
        obs_flag  = (sel != 0) ? b_oflag : a_oflag;
        obs_ready = (sel != 0) ? b_ready : a_ready;
        obs_sat   = (sel != 0) ? b_osat  : a_osat;
        obs_out   = (sel != 0) ? longint'(b_out) : longint'(a_out);
        obs_ch    = (sel != 0) ? int'(b_och) : int'(a_och);
    end

    // Reference model: coefficients and per-channel history, newest at [0].
    int coef_m [2][8];
    int hist_m [2][3][8];
    int shift_m [2] = '{0, 2};
    int ow_m    [2] = '{16, 8};

    function automatic void model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 8; k++) begin
                coef_m[d][k] = 0;
                for (int c = 0; c < 3; c++) hist_m[d][c][k] = 0;
            end
        end
    endfunction

    function automatic void model_push(input int d, input int ch, input int x);
        for (int k = 7; k > 0; k--) hist_m[d][ch][k] = hist_m[d][ch][k-1];
        hist_m[d][ch][0] = x;
    endfunction

    function automatic void model_calc(input int d, input int ch,
                                       output longint val, output bit sat);
        longint acc, div, q, hi, lo;
        acc = 0;
        for (int k = 0; k < 8; k++)
            acc += longint'(coef_m[d][k]) * longint'(hist_m[d][ch][k]);
        div = longint'(1) << shift_m[d];
        q = acc / div;
        if ((acc % div) != 0 && acc < 0) q = q - 1;
        hi = (longint'(1) << (ow_m[d] - 1)) - 1;
        lo = -(longint'(1) << (ow_m[d] - 1));
        sat = 1'b0;
        val = q;
        if (q > hi) begin
            val = hi;
            sat = 1'b1;
        end else if (q < lo) begin
            val = lo;
            sat = 1'b1;
        end
    endfunction

    task automatic drive(input bit f, input int ch, input int x,
                         input bit w, input int k, input int v);
        if (sel != 0) begin
            b_flag = f; b_ch = 2'(ch); b_data = 8'(x);
            b_cwr = w;  b_caddr = 3'(k); b_cdata = 8'(v);
        end else begin
            a_flag = f; a_ch = 1'(ch); a_data = 8'(x);
            a_cwr = w;  a_caddr = 3'(k); a_cdata = 8'(v);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic write_coef(input int k, input int v);
        @(negedge clk);
        drive(0, 0, 0, 1, k, v);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        coef_m[sel][k] = v;
    endtask

    // One sample through the selected DUT, optionally with a coefficient
    // write in the same accept cycle. Checks latency, ready, value, channel, sat.
    task automatic run_sample(input int ch, input int x, input bit w,
                              input int k, input int v, output longint got);
        int     n, low;
        longint ev;
        bit     es;
        @(negedge clk);
        drive(1, ch, x, w, k, v);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        if (w) coef_m[sel][k] = v;
        model_push(sel, ch, x);
        model_calc(sel, ch, ev, es);
        n = 0;
        low = 0;
        while (!obs_flag && n < 40) begin
            if (!obs_ready) low++;
            @(negedge clk);
            n++;
        end
        got = obs_out;
        checks++;
        if (!obs_flag) begin
            errors++;
            $display("FAIL flag_timeout: no output_data_flag after %0d cycles, required within 9", n);
            return;
        end
        checks++;
        if (n != 9) begin
            errors++;
            $display("FAIL latency: got %0d cycles, required 9", n);
        end
        checks++;
        if (low != 9) begin
            errors++;
            $display("FAIL ready_low: input_ready low %0d cycles, required 9", low);
        end
        checks++;
        if (obs_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_at_flag: got %b, required 1", obs_ready);
        end
        checks++;
        if (obs_out != ev) begin
            errors++;
            $display("FAIL out_data: ch %0d got %0d, required %0d", ch, obs_out, ev);
        end
        checks++;
        if (obs_ch != ch) begin
            errors++;
            $display("FAIL out_channel: got %0d, required %0d", obs_ch, ch);
        end
        checks++;
        if (obs_sat !== es) begin
            errors++;
            $display("FAIL out_sat: got %b, required %b", obs_sat, es);
        end
    endtask

    task automatic count_flags(input int cycles, output int pulses, output int not_ready);
        pulses = 0;
        not_ready = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (obs_flag) pulses++;
            if (!obs_ready) not_ready++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b/%b, required 1/1", a_ready, b_ready);
        end
        checks++;
        if (a_oflag !== 1'b0 || b_oflag !== 1'b0) begin
            errors++;
            $display("FAIL reset_flag: got %b/%b, required 0/0", a_oflag, b_oflag);
        end
        checks++;
        if (a_out !== 16'sd0 || b_out !== 8'sd0) begin
            errors++;
            $display("FAIL reset_data: got %0d/%0d, required 0/0", a_out, b_out);
        end
        checks++;
        if (a_osat !== 1'b0 || a_och !== 1'b0 || b_osat !== 1'b0 || b_och !== 2'd0) begin
            errors++;
            $display("FAIL reset_sat_ch: got %b %b %b %b, required all 0", a_osat, a_och, b_osat, b_och);
        end
    endtask

    task automatic test_impulse();
        longint got;
        sel = 0;
        for (int k = 0; k < 8; k++) write_coef(k, k + 1);
        for (int i = 0; i < 8; i++) begin
            run_sample(0, (i == 0) ? 17 : 0, 0, 0, 0, got);
            checks++;
            if (got != longint'(17 * (i + 1))) begin
                errors++;
                $display("FAIL impulse_%0d: got %0d, required %0d", i, got, 17 * (i + 1));
            end
        end
    endtask

    task automatic test_interleave();
        longint got;
        int     exp_v [3] = '{17, 18, 34};
        int     chs   [3] = '{0, 1, 0};
        int     xs    [3] = '{17, 18, 17};
        sel = 0;
        do_reset();
        for (int k = 0; k < 8; k++) write_coef(k, 1);
        for (int i = 0; i < 3; i++) begin
            run_sample(chs[i], xs[i], 0, 0, 0, got);
            checks++;
            if (got != longint'(exp_v[i])) begin
                errors++;
                $display("FAIL interleave_%0d: got %0d, required %0d", i, got, exp_v[i]);
            end
        end
    endtask

    task automatic test_random();
        longint got;
        sel = 0;
        for (int k = 0; k < 8; k++) write_coef(k, int'($urandom_range(0, 255)) - 128);
        for (int i = 0; i < 30; i++) begin
            run_sample(int'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128,
                       ($urandom_range(0, 9) < 3), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 255)) - 128, got);
        end
    endtask

    task automatic test_coef_during_mac();
        longint ev, got;
        bit     es;
        int     n;
        sel = 0;
        @(negedge clk);
        drive(1, 1, 77, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 1, 0, -99);
        model_push(0, 1, 77);
        model_calc(0, 1, ev, es);
        repeat (5) @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        n = 0;
        while (!obs_flag && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!obs_flag || obs_out != ev) begin
            errors++;
            $display("FAIL coef_in_mac: flag %b got %0d, required flag 1 value %0d", obs_flag, obs_out, ev);
        end
        run_sample(1, -33, 0, 0, 0, got);
    endtask

    task automatic test_held_flag();
        longint ev;
        bit     es;
        int     n, pulses, nr;
        sel = 0;
        @(negedge clk);
        drive(1, 0, 9, 0, 0, 0);
        model_push(0, 0, 9);
        model_calc(0, 0, ev, es);
        n = 0;
        @(negedge clk);
        while (!obs_flag && n < 40) begin
            @(negedge clk);
            n++;
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (!obs_flag || obs_out != ev) begin
            errors++;
            $display("FAIL held_flag_result: flag %b got %0d, required flag 1 value %0d", obs_flag, obs_out, ev);
        end
        count_flags(15, pulses, nr);
        checks++;
        if (pulses != 0 || nr != 0) begin
            errors++;
            $display("FAIL held_flag_once: extra flags %0d busy cycles %0d, required 0 and 0", pulses, nr);
        end
    endtask

    task automatic test_saturation();
        longint got;
        sel = 1;
        for (int k = 0; k < 8; k++) write_coef(k, 127);
        for (int i = 0; i < 9; i++) run_sample(0, 127, 0, 0, 0, got);
        checks++;
        if (got != 127 || b_osat !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos: got %0d sat %b, required 127 sat 1", got, b_osat);
        end
        for (int i = 0; i < 9; i++) run_sample(0, -128, 0, 0, 0, got);
        checks++;
        if (got != -128 || b_osat !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg: got %0d sat %b, required -128 sat 1", got, b_osat);
        end
    endtask

    task automatic test_floor();
        longint got;
        sel = 1;
        do_reset();
        write_coef(0, 1);
        run_sample(2, -5, 0, 0, 0, got);
        checks++;
        if (got != -2 || b_osat !== 1'b0) begin
            errors++;
            $display("FAIL floor_shift: got %0d sat %b, required -2 sat 0", got, b_osat);
        end
    endtask

    task automatic test_bad_channel();
        longint got;
        int     pulses, nr;
        sel = 1;
        @(negedge clk);
        drive(1, 3, 100, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        count_flags(15, pulses, nr);
        checks++;
        if (pulses != 0 || nr != 0) begin
            errors++;
            $display("FAIL bad_channel: flags %0d busy cycles %0d, required 0 and 0", pulses, nr);
        end
        for (int k = 1; k < 8; k++) write_coef(k, 3);
        run_sample(1, 11, 0, 0, 0, got);
        run_sample(2, -7, 0, 0, 0, got);
    endtask

    task automatic test_reset_mid_mac();
        longint got;
        int     pulses, nr;
        sel = 0;
        for (int k = 0; k < 8; k++) write_coef(k, 2);
        run_sample(0, 40, 0, 0, 0, got);
        @(negedge clk);
        drive(1, 0, 50, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        checks++;
        if (a_oflag !== 1'b0 || a_out !== 16'sd0 || a_osat !== 1'b0 || a_och !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: flag %b data %0d sat %b ch %b, required all 0",
                     a_oflag, a_out, a_osat, a_och);
        end
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready: got %b, required 1", a_ready);
        end
        count_flags(15, pulses, nr);
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort_no_flag: got %0d flags, required 0", pulses);
        end
        for (int k = 0; k < 8; k++) write_coef(k, 1);
        run_sample(0, 5, 0, 0, 0, got);
        checks++;
        if (got != 5) begin
            errors++;
            $display("FAIL abort_history: got %0d, required 5", got);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sel = 0;
        drive(0, 0, 0, 0, 0, 0);
        sel = 1;
        drive(0, 0, 0, 0, 0, 0);
        sel = 0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_impulse();
        test_interleave();
        test_random();
        test_coef_during_mac();
        test_held_flag();
        test_saturation();
        test_floor();
        test_bad_channel();
        test_reset_mid_mac();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
